// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - combinational execute stage: ALU/immediate result, predicate, branch decision and target
module execute_stage #(
  parameter int DATAW = 32,
  parameter int PCW   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_op,
  input  logic             use_imm,
  input  logic             branch_in,
  input  logic             p_flag_in,
  input  logic [1:0]       shift_dist,
  input  logic [DATAW-1:0] a,
  input  logic [DATAW-1:0] b,
  input  logic [10:0]      imm,
  input  logic [PCW-1:0]   PC_in,
  output logic [DATAW-1:0] ex_out,
  output logic             p_flag_out,
  output logic             branch_out,
  output logic [PCW-1:0]   PC_out
);

  // Width of one immediate lane; shift_dist picks which lane the byte lands in.
  localparam int LANE = DATAW / 4;

  // Clock and reset exist only so every pipeline stage has the same interface.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst_n};

  logic [DATAW-1:0] sum;
  logic [DATAW-1:0] inc;
  logic [DATAW-1:0] one;
  logic [DATAW-1:0] imm_ext;
  logic [DATAW-1:0] imm_shifted;
  logic [PCW-1:0]   pc_off;
  logic             a_gt_b;

  // Arithmetic building blocks; carries are dropped by the DATAW-wide results.
  always_comb begin
    one      = '0;
    one[0]   = 1'b1;
    sum      = a + b;
    inc      = a + one;
    a_gt_b   = (a > b);
  end

  // Place the low immediate byte into the selected lane; bits past DATAW fall off.
  always_comb begin
    imm_ext      = '0;
    imm_ext[7:0] = imm[7:0];
    imm_shifted  = imm_ext << (32'(shift_dist) * LANE);
  end

  // Result select: a true mux so operands of the unselected path cannot leak X into ex_out.
  always_comb begin
    ex_out = '0;
    if (use_imm) begin
      ex_out = imm_shifted;
    end else if (alu_op) begin
      ex_out = inc;
    end else begin
      ex_out = sum;
    end
  end

  // Predicate is produced for every instruction, immediate ones included.
  always_comb begin
    p_flag_out = 1'b0;
    if (alu_op) begin
      p_flag_out = a_gt_b;
    end else begin
      p_flag_out = |sum;
    end
  end

  // Branch uses the predicate that was live when the instruction issued, and the
  // target is always computed from the unsigned 11-bit offset.
  always_comb begin
    branch_out    = branch_in & p_flag_in;
    pc_off        = '0;
    pc_off[10:0]  = imm;
    PC_out        = PC_in + pc_off;
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - scoreboard bench for execute_stage
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_op, use_imm, branch_in, p_flag_in;
  logic [1:0]  shift_dist;
  logic [31:0] a, b;
  logic [10:0] imm;
  logic [31:0] PC_in;
  logic [31:0] ex_out;
  logic        p_flag_out, branch_out;
  logic [31:0] PC_out;

  always #5 clk = ~clk;

  execute_stage #(.DATAW(32), .PCW(32)) dut (
    .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .use_imm(use_imm),
    .branch_in(branch_in), .p_flag_in(p_flag_in), .shift_dist(shift_dist),
    .a(a), .b(b), .imm(imm), .PC_in(PC_in),
    .ex_out(ex_out), .p_flag_out(p_flag_out), .branch_out(branch_out), .PC_out(PC_out)
  );

  typedef struct {
    logic [31:0] ex;
    logic        pf;
    logic        br;
    logic [31:0] pc;
    bit          chk_pf;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  logic vec_valid = 1'b0;

  task automatic cmp(input string name, input string fld, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", name, fld, act, req);
    end
  endtask

  // Monitor: one expected entry is consumed per presented vector.
  always @(negedge clk) begin
    if (vec_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
        mon_e = sb.pop_front();
        cmp(mon_e.name, "ex_out", ex_out, mon_e.ex);
        if (mon_e.chk_pf) cmp(mon_e.name, "p_flag_out", {31'b0, p_flag_out}, {31'b0, mon_e.pf});
        cmp(mon_e.name, "branch_out", {31'b0, branch_out}, {31'b0, mon_e.br});
        cmp(mon_e.name, "PC_out", PC_out, mon_e.pc);
      end
    end
  end

  task automatic apply(input string name, input logic ao, input logic ui, input logic bi, input logic pi,
                       input logic [1:0] sd, input logic [31:0] av, input logic [31:0] bv,
                       input logic [10:0] im, input logic [31:0] pc,
                       input logic [31:0] eex, input logic epf, input logic ebr, input logic [31:0] epc,
                       input bit cpf);
    exp_t e;
    @(posedge clk);
    #1;
    alu_op = ao; use_imm = ui; branch_in = bi; p_flag_in = pi;
    shift_dist = sd; a = av; b = bv; imm = im; PC_in = pc;
    e.ex = eex; e.pf = epf; e.br = ebr; e.pc = epc; e.chk_pf = cpf; e.name = name;
    sb.push_back(e);
    vec_valid = 1'b1;
  endtask

  // Reference equations written directly from the behavioural description.
  task automatic ref_model(input logic ao, input logic ui, input logic bi, input logic pi,
                           input logic [1:0] sd, input logic [31:0] av, input logic [31:0] bv,
                           input logic [10:0] im, input logic [31:0] pc,
                           output logic [31:0] eex, output logic epf, output logic ebr, output logic [31:0] epc);
    logic [32:0] s;
    s = {1'b0, av} + {1'b0, bv};
    if (ui) begin
      case (sd)
        2'd0: eex = {24'h0, im[7:0]};
        2'd1: eex = {16'h0, im[7:0], 8'h0};
        2'd2: eex = {8'h0, im[7:0], 16'h0};
        default: eex = {im[7:0], 24'h0};
      endcase
    end else if (ao) begin
      eex = av + 32'd1;
    end else begin
      eex = s[31:0];
    end
    epf = ao ? (av > bv) : (s[31:0] != 32'd0);
    ebr = bi & pi;
    epc = pc + {21'd0, im};
  endtask

  initial begin
    logic [31:0] rex, rpc, ra, rb, rp;
    logic        rpf, rbr, rao, rbi, rpi;
    logic [1:0]  rsd;
    logic [10:0] rim;

    alu_op = 0; use_imm = 0; branch_in = 0; p_flag_in = 0; shift_dist = 0;
    a = 0; b = 0; imm = 0; PC_in = 0;

    // Held in reset: outputs still follow inputs.
    apply("imm_sd2_rst", 0, 1, 0, 0, 2'd2, 32'd3, 32'd4, 11'h7AB, 32'h1000, 32'h00AB0000, 1, 0, 32'h17AB, 1);
    apply("imm_sd0_rst", 0, 1, 0, 0, 2'd0, 32'd3, 32'd4, 11'h7AB, 32'h1000, 32'h000000AB, 1, 0, 32'h17AB, 1);
    rst_n = 1'b1;
    apply("imm_sd3", 0, 1, 0, 0, 2'd3, 32'd3, 32'd4, 11'h7AB, 32'h1000, 32'hAB000000, 1, 0, 32'h17AB, 1);
    apply("imm_sd1_gt", 1, 1, 0, 0, 2'd1, 32'd5, 32'd7, 11'h7AB, 32'h1000, 32'h0000AB00, 0, 0, 32'h17AB, 1);
    apply("add_wrap", 0, 0, 0, 0, 2'd0, 32'hFFFFFFFF, 32'd1, 11'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1);
    apply("add_3_4", 0, 0, 0, 0, 2'd0, 32'd3, 32'd4, 11'h0, 32'h0, 32'd7, 1, 0, 32'h0, 1);
    apply("inc_5_7", 1, 0, 0, 0, 2'd0, 32'd5, 32'd7, 11'h0, 32'h0, 32'd6, 0, 0, 32'h0, 1);
    apply("inc_unsigned", 1, 0, 0, 0, 2'd0, 32'h80000000, 32'd1, 11'h0, 32'h0, 32'h80000001, 1, 0, 32'h0, 1);
    apply("inc_wrap", 1, 0, 0, 0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 11'h0, 32'h0, 32'h0, 1, 0, 32'h0, 1);
    apply("inc_equal", 1, 0, 0, 0, 2'd0, 32'd7, 32'd7, 11'h0, 32'h0, 32'd8, 0, 0, 32'h0, 1);
    apply("br_10", 0, 0, 1, 0, 2'd0, 32'd3, 32'd4, 11'h0, 32'h0, 32'd7, 1, 0, 32'h0, 1);
    apply("br_01", 0, 0, 0, 1, 2'd0, 32'd3, 32'd4, 11'h0, 32'h0, 32'd7, 1, 0, 32'h0, 1);
    apply("br_11", 0, 0, 1, 1, 2'd0, 32'd3, 32'd4, 11'h0, 32'h0, 32'd7, 1, 1, 32'h0, 1);
    apply("br_11_pf0", 0, 0, 1, 1, 2'd0, 32'hFFFFFFFF, 32'd1, 11'h0, 32'h0, 32'h0, 0, 1, 32'h0, 1);
    apply("pc_wrap", 0, 0, 0, 0, 2'd0, 32'd0, 32'd0, 11'h001, 32'hFFFFFFFF, 32'h0, 0, 0, 32'h0, 1);
    apply("pc_max_off", 0, 0, 0, 0, 2'd0, 32'd0, 32'd0, 11'h7FF, 32'h0, 32'h0, 0, 0, 32'h7FF, 1);
    apply("inc_b_x", 1, 0, 0, 0, 2'd0, 32'd10, 32'hxxxxxxxx, 11'h0, 32'h0, 32'd11, 0, 0, 32'h0, 0);
    apply("imm_ab_x", 0, 1, 0, 0, 2'd1, 32'hxxxxxxxx, 32'hxxxxxxxx, 11'h012, 32'h0, 32'h00001200, 0, 0, 32'h12, 0);

    // Random sweep with reset asserted through the middle of each pass.
    for (int ui = 0; ui < 2; ui++) begin
      for (int i = 0; i < 200; i++) begin
        rst_n = (i >= 50 && i < 150) ? 1'b0 : 1'b1;
        rao = 1'($urandom); rbi = 1'($urandom); rpi = 1'($urandom);
        rsd = 2'($urandom); ra = $urandom; rb = (i % 7 == 0) ? ra : $urandom;
        rim = 11'($urandom); rp = $urandom;
        ref_model(rao, 1'(ui), rbi, rpi, rsd, ra, rb, rim, rp, rex, rpf, rbr, rpc);
        apply("rand", rao, 1'(ui), rbi, rpi, rsd, ra, rb, rim, rp, rex, rpf, rbr, rpc, 1);
      end
    end
    rst_n = 1'b1;

    @(posedge clk);
    #1;
    vec_valid = 1'b0;
    @(posedge clk);
    cmp("drain", "leftover", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
